// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus between instruction fetch (IF) and load/store (LS).
//   One transaction is outstanding at a time. LS has fixed priority over IF.
//   A cycle budget aborts transactions that never see a bus response.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   if_req_i/if_addr_i/if_flush_i   fetch request, address, discard request
//   if_gnt_o/if_rvalid_o/if_rdata_o fetch accept pulse, response pulse, data
//   if_stallreq_o                   fetch waiting on the bus (combinational)
//   ls_req_i/ls_we_i/ls_be_i        load/store request, write enable, byte enables
//   ls_addr_i/ls_wdata_i            load/store address, write data
//   ls_gnt_o/ls_rvalid_o/ls_rdata_o load/store accept pulse, response pulse, data
//   ls_stallreq_o                   load/store waiting on the bus (combinational)
//   bus_req_o/bus_we_o/bus_be_o     bus request, write, byte enables
//   bus_addr_o/bus_wdata_o          bus address, write data
//   bus_gnt_i/bus_rvalid_i          bus accept, bus response
//   bus_rdata_i                     bus read data
//   bus_err_o                       pulse on timeout abort
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_stallreq_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned BEW = 4;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_IF  = 3'd1,
    S_WAIT_IF = 3'd2,
    S_REQ_LS  = 3'd3,
    S_WAIT_LS = 3'd4
  } state_e;

  state_e          state_q;
  logic            we_q;
  logic [BEW-1:0]  be_q;
  logic [DW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            bus_req_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            discard_q;
  logic            if_gnt_q;
  logic            if_rvalid_q;
  logic [DW-1:0]   if_rdata_q;
  logic            ls_gnt_q;
  logic            ls_rvalid_q;
  logic [DW-1:0]   ls_rdata_q;
  logic            err_q;

  logic own_if;
  logic own_ls;
  logic in_req;
  logic in_wait;
  logic req_live;
  logic done;
  logic tmo;

  // Ownership and phase decode
  assign own_if  = (state_q == S_REQ_IF) || (state_q == S_WAIT_IF);
  assign own_ls  = (state_q == S_REQ_LS) || (state_q == S_WAIT_LS);
  assign in_req  = (state_q == S_REQ_IF) || (state_q == S_REQ_LS);
  assign in_wait = (state_q == S_WAIT_IF) || (state_q == S_WAIT_LS);

  // The first REQ cycle only sets up bus_req; the bus is live from the next one
  assign req_live = in_req && bus_req_q;

  // Response either after a grant, or together with the grant
  assign done = (req_live && bus_gnt_i && bus_rvalid_i) || (in_wait && bus_rvalid_i);

  // Budget counts from the first cycle bus_req_o is high
  assign cnt_d = cnt_q + CW'(1);
  assign tmo   = !done && (req_live || in_wait) && (cnt_q == CNT_LAST);

  // Transaction FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_req_q   <= 1'b0;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ls_req_i) begin
            we_q      <= ls_we_i;
            be_q      <= ls_be_i;
            addr_q    <= ls_addr_i;
            wdata_q   <= ls_wdata_i;
            ls_gnt_q  <= 1'b1;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            state_q   <= S_REQ_LS;
          end else if (if_req_i && !if_flush_i) begin
            we_q      <= 1'b0;
            be_q      <= {BEW{1'b1}};
            addr_q    <= if_addr_i;
            wdata_q   <= '0;
            if_gnt_q  <= 1'b1;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            state_q   <= S_REQ_IF;
          end
        end
        S_REQ_IF, S_WAIT_IF, S_REQ_LS, S_WAIT_LS: begin
          if (req_live || in_wait) begin
            cnt_q <= cnt_d;
          end
          if (own_if && if_flush_i) begin
            discard_q <= 1'b1;
          end
          if (done || tmo) begin
            // Completion or abort: deliver to the owner and release the bus
            state_q   <= S_IDLE;
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            err_q     <= tmo;
            if (own_if) begin
              if_rdata_q  <= tmo ? '0 : bus_rdata_i;
              if_rvalid_q <= !(discard_q || if_flush_i);
            end else begin
              ls_rdata_q  <= tmo ? '0 : bus_rdata_i;
              ls_rvalid_q <= 1'b1;
            end
          end else if (req_live && bus_gnt_i) begin
            bus_req_q <= 1'b0;
            state_q   <= own_if ? S_WAIT_IF : S_WAIT_LS;
          end else if (in_req) begin
            bus_req_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall requests towards the pipeline controller
  assign if_stallreq_o = (if_req_i && !if_gnt_q && !if_flush_i) || (own_if && !discard_q);
  assign ls_stallreq_o = (ls_req_i && !ls_gnt_q) || own_ls;

  assign if_gnt_o    = if_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_gnt_o    = ls_gnt_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = we_q;
  assign bus_be_o    = be_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter with a 4-cycle bus budget.
//   Inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_stallreq_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        ls_stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_i      (if_req_i),
    .if_addr_i     (if_addr_i),
    .if_flush_i    (if_flush_i),
    .if_gnt_o      (if_gnt_o),
    .if_rvalid_o   (if_rvalid_o),
    .if_rdata_o    (if_rdata_o),
    .if_stallreq_o (if_stallreq_o),
    .ls_req_i      (ls_req_i),
    .ls_we_i       (ls_we_i),
    .ls_be_i       (ls_be_i),
    .ls_addr_i     (ls_addr_i),
    .ls_wdata_i    (ls_wdata_i),
    .ls_gnt_o      (ls_gnt_o),
    .ls_rvalid_o   (ls_rvalid_o),
    .ls_rdata_o    (ls_rdata_o),
    .ls_stallreq_o (ls_stallreq_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_be_o      (bus_be_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i),
    .bus_err_o     (bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every registered output must be zero
  task automatic chk_quiet(input string tag);
    chk({tag, ".if_gnt"},    32'(if_gnt_o),    32'h0);
    chk({tag, ".if_rvalid"}, 32'(if_rvalid_o), 32'h0);
    chk({tag, ".if_rdata"},  if_rdata_o,       32'h0);
    chk({tag, ".ls_gnt"},    32'(ls_gnt_o),    32'h0);
    chk({tag, ".ls_rvalid"}, 32'(ls_rvalid_o), 32'h0);
    chk({tag, ".ls_rdata"},  ls_rdata_o,       32'h0);
    chk({tag, ".bus_req"},   32'(bus_req_o),   32'h0);
    chk({tag, ".bus_we"},    32'(bus_we_o),    32'h0);
    chk({tag, ".bus_be"},    32'(bus_be_o),    32'h0);
    chk({tag, ".bus_addr"},  bus_addr_o,       32'h0);
    chk({tag, ".bus_wdata"}, bus_wdata_o,      32'h0);
    chk({tag, ".bus_err"},   32'(bus_err_o),   32'h0);
  endtask

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = '0; ls_addr_i = '0; ls_wdata_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;

    // Reset state
    repeat (3) cyc();
    #1;
    chk_quiet("rst");
    chk("rst.if_stall", 32'(if_stallreq_o), 32'h0);
    chk("rst.ls_stall", 32'(ls_stallreq_o), 32'h0);
    rst = 1'b0;

    // Single load: gnt at N+1, response at N+2
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h100;
    cyc(); #1;
    chk("ld.gnt", 32'(ls_gnt_o), 32'h1);
    chk("ld.req_n", 32'(bus_req_o), 32'h0);
    chk("ld.stall_n", 32'(ls_stallreq_o), 32'h1);
    cyc(); ls_req_i = 1'b0; bus_gnt_i = 1'b1; #1;
    chk("ld.req_n1", 32'(bus_req_o), 32'h1);
    chk("ld.addr", bus_addr_o, 32'h100);
    chk("ld.we", 32'(bus_we_o), 32'h0);
    chk("ld.be", 32'(bus_be_o), 32'hF);
    chk("ld.gnt_pulse", 32'(ls_gnt_o), 32'h0);
    chk("ld.stall_n1", 32'(ls_stallreq_o), 32'h1);
    cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF; #1;
    chk("ld.req_n2", 32'(bus_req_o), 32'h0);
    chk("ld.rvalid_n2", 32'(ls_rvalid_o), 32'h0);
    cyc(); bus_rvalid_i = 1'b0; #1;
    chk("ld.rvalid", 32'(ls_rvalid_o), 32'h1);
    chk("ld.rdata", ls_rdata_o, 32'hDEADBEEF);
    chk("ld.stall_n3", 32'(ls_stallreq_o), 32'h0);
    chk("ld.err", 32'(bus_err_o), 32'h0);
    chk("ld.if_rvalid", 32'(if_rvalid_o), 32'h0);
    cyc(); #1;
    chk("ld.rvalid_pulse", 32'(ls_rvalid_o), 32'h0);

    // Contention: LS first, IF granted the cycle after ls_rvalid_o
    if_req_i = 1'b1; if_addr_i = 32'h200;
    ls_req_i = 1'b1; ls_addr_i = 32'h300; ls_we_i = 1'b0; ls_be_i = 4'hF;
    cyc(); #1;
    chk("ct.ls_gnt", 32'(ls_gnt_o), 32'h1);
    chk("ct.if_gnt0", 32'(if_gnt_o), 32'h0);
    chk("ct.if_stall0", 32'(if_stallreq_o), 32'h1);
    cyc(); ls_req_i = 1'b0; bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hA5A5A5A5; #1;
    chk("ct.bus_req", 32'(bus_req_o), 32'h1);
    chk("ct.bus_addr", bus_addr_o, 32'h300);
    chk("ct.if_stall1", 32'(if_stallreq_o), 32'h1);
    cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; #1;
    chk("ct.ls_rvalid", 32'(ls_rvalid_o), 32'h1);
    chk("ct.ls_rdata", ls_rdata_o, 32'hA5A5A5A5);
    chk("ct.if_gnt1", 32'(if_gnt_o), 32'h0);
    chk("ct.if_stall2", 32'(if_stallreq_o), 32'h1);
    chk("ct.ls_stall", 32'(ls_stallreq_o), 32'h0);
    cyc(); #1;
    chk("ct.if_gnt", 32'(if_gnt_o), 32'h1);
    chk("ct.if_stall3", 32'(if_stallreq_o), 32'h1);
    cyc(); if_req_i = 1'b0; bus_gnt_i = 1'b1; #1;
    chk("ct.if_bus_req", 32'(bus_req_o), 32'h1);
    chk("ct.if_addr", bus_addr_o, 32'h200);
    chk("ct.if_be", 32'(bus_be_o), 32'hF);
    chk("ct.if_we", 32'(bus_we_o), 32'h0);
    chk("ct.if_wdata", bus_wdata_o, 32'h0);
    cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11223344; #1;
    chk("ct.if_req_drop", 32'(bus_req_o), 32'h0);
    chk("ct.if_rvalid0", 32'(if_rvalid_o), 32'h0);
    cyc(); bus_rvalid_i = 1'b0; #1;
    chk("ct.if_rvalid", 32'(if_rvalid_o), 32'h1);
    chk("ct.if_rdata", if_rdata_o, 32'h11223344);
    chk("ct.if_stall4", 32'(if_stallreq_o), 32'h0);

    // Store: fields latched and stable until bus_gnt_i
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0011; ls_addr_i = 32'h400; ls_wdata_i = 32'h12345678;
    cyc(); #1;
    chk("st.gnt", 32'(ls_gnt_o), 32'h1);
    cyc(); ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_wdata_i = 32'hFFFFFFFF; #1;
    chk("st.req", 32'(bus_req_o), 32'h1);
    chk("st.we", 32'(bus_we_o), 32'h1);
    chk("st.be", 32'(bus_be_o), 32'h3);
    chk("st.wdata", bus_wdata_o, 32'h12345678);
    chk("st.addr", bus_addr_o, 32'h400);
    cyc(); bus_gnt_i = 1'b1; #1;
    chk("st.req_hold", 32'(bus_req_o), 32'h1);
    chk("st.wdata_hold", bus_wdata_o, 32'h12345678);
    chk("st.be_hold", 32'(bus_be_o), 32'h3);
    cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55AA55AA; #1;
    chk("st.req_drop", 32'(bus_req_o), 32'h0);
    cyc(); bus_rvalid_i = 1'b0; #1;
    chk("st.rvalid", 32'(ls_rvalid_o), 32'h1);
    chk("st.rdata", ls_rdata_o, 32'h55AA55AA);

    // Fetch flush in WAIT_IF: bus completes, response suppressed
    if_req_i = 1'b1; if_addr_i = 32'h500;
    cyc(); #1;
    chk("fl.gnt", 32'(if_gnt_o), 32'h1);
    cyc(); if_req_i = 1'b0; bus_gnt_i = 1'b1; #1;
    chk("fl.req", 32'(bus_req_o), 32'h1);
    chk("fl.addr", bus_addr_o, 32'h500);
    cyc(); bus_gnt_i = 1'b0; if_flush_i = 1'b1; #1;
    chk("fl.wait", 32'(bus_req_o), 32'h0);
    cyc(); if_flush_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFEF00D; #1;
    chk("fl.stall", 32'(if_stallreq_o), 32'h0);
    cyc(); bus_rvalid_i = 1'b0; #1;
    chk("fl.rvalid", 32'(if_rvalid_o), 32'h0);
    chk("fl.err", 32'(bus_err_o), 32'h0);
    if_req_i = 1'b1; if_addr_i = 32'h600;
    cyc(); #1;
    chk("fl.gnt2", 32'(if_gnt_o), 32'h1);
    cyc(); if_req_i = 1'b0; bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0BADC0DE; #1;
    chk("fl.addr2", bus_addr_o, 32'h600);
    cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; #1;
    chk("fl.rvalid2", 32'(if_rvalid_o), 32'h1);
    chk("fl.rdata2", if_rdata_o, 32'h0BADC0DE);

    // Timeout: bus never grants, abort 4 cycles after bus_req_o rises
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h700;
    cyc(); #1;
    chk("to.gnt", 32'(ls_gnt_o), 32'h1);
    cyc(); ls_req_i = 1'b0; #1;
    chk("to.req", 32'(bus_req_o), 32'h1);
    chk("to.err_early", 32'(bus_err_o), 32'h0);
    for (int i = 2; i <= 4; i++) begin
      cyc(); #1;
      chk($sformatf("to.req_c%0d", i), 32'(bus_req_o), 32'h1);
      chk($sformatf("to.err_c%0d", i), 32'(bus_err_o), 32'h0);
      chk($sformatf("to.rvalid_c%0d", i), 32'(ls_rvalid_o), 32'h0);
    end
    cyc(); #1;
    chk("to.err", 32'(bus_err_o), 32'h1);
    chk("to.rvalid", 32'(ls_rvalid_o), 32'h1);
    chk("to.rdata", ls_rdata_o, 32'h0);
    chk("to.req_drop", 32'(bus_req_o), 32'h0);
    chk("to.stall", 32'(ls_stallreq_o), 32'h0);
    cyc(); #1;
    chk("to.err_pulse", 32'(bus_err_o), 32'h0);
    chk("to.rvalid_pulse", 32'(ls_rvalid_o), 32'h0);
    chk("to.idle_req", 32'(bus_req_o), 32'h0);

    // Reset in WAIT_LS abandons the transaction
    ls_req_i = 1'b1; ls_addr_i = 32'h900;
    cyc(); #1;
    chk("rs.gnt", 32'(ls_gnt_o), 32'h1);
    cyc(); ls_req_i = 1'b0; bus_gnt_i = 1'b1; #1;
    chk("rs.req", 32'(bus_req_o), 32'h1);
    cyc(); bus_gnt_i = 1'b0; rst = 1'b1; #1;
    chk("rs.wait", 32'(ls_stallreq_o), 32'h1);
    cyc(); rst = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF; #1;
    chk_quiet("rs.after");
    chk("rs.ls_stall", 32'(ls_stallreq_o), 32'h0);
    cyc(); bus_rvalid_i = 1'b0; #1;
    chk("rs.rvalid", 32'(ls_rvalid_o), 32'h0);
    chk("rs.rdata", ls_rdata_o, 32'h0);
    chk("rs.err", 32'(bus_err_o), 32'h0);
    cyc(); #1;
    chk("rs.rvalid2", 32'(ls_rvalid_o), 32'h0);

    // Zero-wait bus after reset: accept N, response N+2
    ls_req_i = 1'b1; ls_addr_i = 32'hA00;
    cyc(); #1;
    chk("zw.gnt", 32'(ls_gnt_o), 32'h1);
    cyc(); ls_req_i = 1'b0; bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h13579BDF; #1;
    chk("zw.addr", bus_addr_o, 32'hA00);
    cyc(); bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; #1;
    chk("zw.rvalid", 32'(ls_rvalid_o), 32'h1);
    chk("zw.rdata", ls_rdata_o, 32'h13579BDF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
